// File: rtl/pid_timing_pkg.sv
// Shared timing types for the PID sample scheduler.
// Holds the scheduler state encoding and datapath limits.
package pid_timing_pkg;

    localparam int          DEF_CNT_W  = 64;
    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } sched_state_t;

endpackage

// File: rtl/pid_sample_scheduler.sv
// Fixed-period sample strobe generator for the PID core.
// Owns the timer clear and reports elapsed time per delivered sample.
module pid_sample_scheduler
    import pid_timing_pkg::*;
#(
    parameter int          CNT_W          = DEF_CNT_W,
    parameter int unsigned PERIOD_DEFAULT = 100000,
    parameter int          MISS_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              period_load,
    input  logic              clear_status,
    input  logic [CNT_W-1:0]  counter_timer,
    input  logic              overflow,
    output logic              reset_timer,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [CNT_W-1:0]  sample_dt,
    output logic [CNT_W-1:0]  sample_stamp,
    output logic [MISS_W-1:0] missed_count,
    output logic              overrun,
    output logic              timer_fault
);

    sched_state_t     state;
    sched_state_t     state_nx;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] deadline;
    logic [CNT_W-1:0] last_stamp;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] dt_new;
    logic [CNT_W-1:0] dl_next;
    logic [CNT_W-1:0] period_new;
    logic [CNT_W:0]   dl_sum;
    logic             in_run;
    logic             park;
    logic             fault;
    logic             take;
    logic             hit;
    logic             fire;
    logic             drop;

    assign in_run = (state == RUN);
    assign park   = in_run & ~enable;
    assign fault  = in_run & enable & overflow;
    assign take   = sample_valid & sample_ready;
    assign hit    = in_run & enable & ~overflow
                  & (counter_timer >= deadline);
    assign fire   = hit & (~sample_valid | sample_ready);
    assign drop   = hit & sample_valid & ~sample_ready;

    // A same-cycle accept makes the accepted stamp the new reference.
    assign base   = take ? sample_stamp : last_stamp;
    assign dt_new = counter_timer - base;

    // Deadline advance pins at all-ones instead of wrapping.
    assign dl_sum  = {1'b0, deadline} + {1'b0, period_reg};
    assign dl_next = dl_sum[CNT_W] ? '1 : dl_sum[CNT_W-1:0];

    assign period_new =
        (period_in < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD)
                                         : period_in;

    // Timer is held clear whenever the scheduler is not running.
    assign reset_timer = ~in_run;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; disable beats overflow restart.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (enable) state_nx = ARM;
            ARM:     state_nx = RUN;
            RUN: begin
                if (!enable)       state_nx = IDLE;
                else if (overflow) state_nx = ARM;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Period register, clamped to the minimum usable period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           period_reg <= CNT_W'(PERIOD_DEFAULT);
        else if (period_load) period_reg <= period_new;
    end

    // Deadline and reference stamp; both rebase while arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deadline   <= '0;
            last_stamp <= '0;
        end else if (state == ARM) begin
            deadline   <= period_reg;
            last_stamp <= '0;
        end else begin
            if (hit)  deadline   <= dl_next;
            if (take) last_stamp <= sample_stamp;
        end
    end

    // Output sample slot; held stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            sample_dt    <= '0;
            sample_stamp <= '0;
        end else if (park) begin
            sample_valid <= 1'b0;
        end else if (fire) begin
            sample_valid <= 1'b1;
            sample_dt    <= dt_new;
            sample_stamp <= counter_timer;
        end else if (take) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky status; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_count <= '0;
            overrun      <= 1'b0;
            timer_fault  <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
                if (clear_status)
                    missed_count <= MISS_W'(1);
                else if (~&missed_count)
                    missed_count <= missed_count + MISS_W'(1);
            end else if (clear_status) begin
                overrun      <= 1'b0;
                missed_count <= '0;
            end
            if (fault)             timer_fault <= 1'b1;
            else if (clear_status) timer_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pid_sample_scheduler.sv
// Scoreboard bench for pid_sample_scheduler.
// Reference model predicts delivered samples and status.
module tb_pid_sample_scheduler;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;

    typedef struct {
        logic [63:0] dt;
        logic [63:0] st;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] period_in = '0;
    logic        period_load = 1'b0;
    logic        clear_status = 1'b0;
    logic [63:0] cnt = '0;
    logic        overflow = 1'b0;
    logic        reset_timer;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [63:0] sample_dt;
    logic [63:0] sample_stamp;
    logic [15:0] missed_count;
    logic        overrun;
    logic        timer_fault;

    int n_chk = 0;
    int n_pass = 0;

    smp_t exp_q[$];
    smp_t cur;

    int          m_mode;
    logic [63:0] m_period, m_dead, m_last, m_stamp;
    bit          m_valid, m_ovr, m_flt;
    int          m_miss;

    pid_sample_scheduler #(
        .CNT_W(64), .PERIOD_DEFAULT(100000), .MISS_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .period_in(period_in), .period_load(period_load),
        .clear_status(clear_status), .counter_timer(cnt),
        .overflow(overflow), .reset_timer(reset_timer),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_dt(sample_dt), .sample_stamp(sample_stamp),
        .missed_count(missed_count), .overrun(overrun),
        .timer_fault(timer_fault)
    );

    always #5 clk = ~clk;

    // Free-running timer cleared by the scheduler.
    always @(posedge clk) cnt <= reset_timer ? 64'd0 : cnt + 64'd1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_period = 64'd100000; m_dead = 0;
        m_last = 0; m_stamp = 0; m_valid = 0;
        m_ovr = 0; m_flt = 0; m_miss = 0;
        exp_q.delete();
    endfunction

    // One clock of behaviour, given inputs and the timer reading.
    function automatic void model_step(bit en, bit rdy, bit ovf,
                                       bit pl, bit clr,
                                       logic [63:0] pin,
                                       logic [63:0] t);
        bit had = m_valid;
        bit take = had && rdy;
        logic [63:0] ref_st = take ? m_stamp : m_last;
        smp_t s;
        if (take) begin m_last = m_stamp; m_valid = 0; end
        if (clr) begin m_miss = 0; m_ovr = 0; m_flt = 0; end
        if (m_mode == M_IDLE) begin
            if (en) m_mode = M_ARM;
        end else if (m_mode == M_ARM) begin
            m_mode = M_RUN; m_dead = m_period; m_last = 0;
        end else if (!en) begin
            m_mode = M_IDLE; m_valid = 0;
        end else if (ovf) begin
            m_flt = 1; m_mode = M_ARM;
        end else if (t >= m_dead) begin
            if (m_dead > ~m_period) m_dead = '1;
            else m_dead = m_dead + m_period;
            if (had && !rdy) begin
                if (m_miss < 65535) m_miss++;
                m_ovr = 1;
            end else begin
                m_valid = 1; m_stamp = t;
                s.dt = t - ref_st; s.st = t;
                exp_q.push_back(s);
            end
        end
        if (pl) m_period = (pin < 2) ? 64'd2 : pin;
    endfunction

    task automatic step(input bit en, input bit rdy, input bit ovf,
                        input bit pl, input bit clr,
                        input logic [63:0] pin);
        @(negedge clk);
        enable = en; sample_ready = rdy; overflow = ovf;
        period_load = pl; clear_status = clr; period_in = pin;
        model_step(en, rdy, ovf, pl, clr, pin, cnt);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 0; enable = 0; overflow = 0;
        period_load = 0; clear_status = 0;
        model_reset();
        #1;
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_reset_timer", 64'(reset_timer), 64'd1);
        chk("rst_missed", 64'(missed_count), 64'd0);
        chk("rst_dt", sample_dt, 64'd0);
        chk("rst_stamp", sample_stamp, 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_fault", 64'(timer_fault), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_step(0, sample_ready, 0, 0, 0, 0, cnt);
    endtask

    // Monitor: checks status each cycle and pops on new samples.
    initial begin
        bit pv = 0;
        smp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pv = 0;
            end else begin
                chk("reset_timer", 64'(reset_timer),
                    64'(m_mode != M_RUN));
                chk("valid", 64'(sample_valid), 64'(m_valid));
                chk("missed", 64'(missed_count), 64'(m_miss));
                chk("overrun", 64'(overrun), 64'(m_ovr));
                chk("fault", 64'(timer_fault), 64'(m_flt));
                if (sample_valid && (!pv || sample_ready)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sample", sample_stamp, '1);
                    end else begin
                        e = exp_q.pop_front();
                        cur = e;
                        chk("dt", sample_dt, e.dt);
                        chk("stamp", sample_stamp, e.st);
                    end
                end else if (sample_valid) begin
                    chk("hold_dt", sample_dt, cur.dt);
                    chk("hold_stamp", sample_stamp, cur.st);
                end
                pv = sample_valid;
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("init_valid", 64'(sample_valid), 64'd0);
        chk("init_reset_timer", 64'(reset_timer), 64'd1);
        chk("init_missed", 64'(missed_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_step(0, 0, 0, 0, 0, 0, cnt);

        // Period 10, always ready.
        step(0, 1, 0, 1, 0, 64'd10);
        repeat (45) step(1, 1, 0, 0, 0, 0);
        // Stall across three deadlines, then release.
        repeat (30) step(1, 0, 0, 0, 0, 0);
        repeat (25) step(1, 1, 0, 0, 0, 0);
        // Load period 0 (clamps to 2) mid-run.
        step(1, 1, 0, 1, 0, 64'd0);
        repeat (12) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 64'd7);
        repeat (20) step(1, 1, 0, 0, 0, 0);
        // Overflow restart.
        step(1, 1, 1, 0, 0, 0);
        repeat (20) step(1, 1, 0, 0, 0, 0);
        // Clear coinciding with drops.
        repeat (20) step(1, 0, 0, 0, 1, 0);
        repeat (10) step(1, 1, 0, 0, 0, 0);
        // Disable while a sample is pending.
        repeat (12) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        repeat (15) step(1, 1, 0, 0, 0, 0);
        // Reset mid-run with a pending sample.
        repeat (10) step(1, 0, 0, 0, 0, 0);
        reset_pulse();
        step(0, 1, 0, 1, 0, 64'd5);
        repeat (20) step(1, 1, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit en  = ($urandom_range(0, 99) != 0);
            bit rdy = ($urandom_range(0, 9) < 7);
            bit ovf = ($urandom_range(0, 99) == 0);
            bit pl  = ($urandom_range(0, 49) == 0);
            bit clr = ($urandom_range(0, 29) == 0);
            logic [63:0] pin = 64'($urandom_range(0, 15));
            if (i == 1500) reset_pulse();
            step(en, rdy, ovf, pl, clr, pin);
        end
        repeat (5) step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
